axi_lite_reg_slave: RTL and testbench
=====================================

# axi_lite_reg_slave

AXI-Lite responder (slave end) exposing a bank of REG_NUM read/write control registers to a master over the AXI-Lite channel set. It terminates the slave side of the bus, decodes word addresses, applies byte strobes, and presents register contents to the surrounding logic as a flat vector. It also emits one-cycle write strobes, so control/status blocks can attach to a CPU or testbench master without their own bus logic.

## Interface
- ADDR_W, 8, byte address width of awaddr/araddr
- DATA_W, 32, data width; legal values 32 or 64
- REG_NUM, 16, number of registers; must satisfy REG_NUM*DATA_W/8 <= 2**ADDR_W
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- awvalid/awready  in/out  1/1  write address handshake
- awaddr  in  ADDR_W  write byte address
- awprot  in  3  ignored
- wvalid/wready  in/out  1/1  write data handshake
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte enables
- bvalid/bready  out/in  1/1  write response handshake
- bresp  out  2  write response
- arvalid/arready  in/out  1/1  read address handshake
- araddr  in  ADDR_W  read byte address
- arprot  in  3  ignored
- rvalid/rready  out/in  1/1  read data handshake
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- reg_q  out  REG_NUM*DATA_W  register contents; register i at bits [i*DATA_W +: DATA_W]
- wr_stb  out  REG_NUM  one-cycle pulse per register, high in the cycle after that register is committed

## Operation
- Address decode: LSB = log2(DATA_W/8). Index = addr[ADDR_W-1:LSB]; low LSB bits are ignored. Index >= REG_NUM is out of range.
- Write FSM states:
  - WR_COLLECT (reset state):
    - awready = !aw_held; wready = !w_held.
    - AW and W are accepted independently, in either order or in the same cycle; awaddr and wdata/wstrb are latched on handshake.
    - Once both are held (including the same-edge case), go to WR_COMMIT.
  - WR_COMMIT (one cycle):
    - awready = wready = 0.
    - In range: for each byte b with wstrb[b]=1, reg[idx][8b+:8] <= wdata[8b+:8]; wr_stb[idx] pulses. Registered, visible the next cycle.
    - Out of range: no register change, no wr_stb.
    - Set bvalid=1, bresp = 2'b00 (OKAY) or 2'b10 (SLVERR). Go to WR_RESP.
  - WR_RESP: hold bvalid/bresp stable until bready. On the handshake edge, clear bvalid and the held flags, then return to WR_COLLECT.
- wstrb = 0 on an in-range address: OKAY response and wr_stb pulse, register unchanged.
- Read FSM states:
  - RD_IDLE (reset state):
    - arready = 1.
    - On the handshake edge, register rdata = reg[idx] and rresp = OKAY, or rdata = 0 and rresp = SLVERR if out of range.
    - Set rvalid=1 and go to RD_RESP.
  - RD_RESP: arready = 0; rdata/rresp/rvalid held stable until rready. On the handshake edge, clear rvalid and return to RD_IDLE.
- Read and write paths are fully independent and may be active simultaneously.
- No outstanding-transaction queueing: one write and one read in flight at most.

## Timing
- Reset values: awready=wready=arready=0; bvalid=rvalid=0; bresp=rresp=0; rdata=0; reg_q=0; wr_stb=0; both FSMs in their idle states. Readies rise in the first cycle after rst deasserts.
- Write latency: last of AW/W handshake at edge N → commit and bvalid=1 at edge N+1 → reg_q updated and wr_stb high in cycle N+1. Minimum write throughput is one transaction per 3 cycles with bready tied high.
- Read latency: AR handshake at edge N → rvalid/rdata valid after edge N. Minimum read throughput is one per 2 cycles with rready tied high.
- Read and commit to the same register at the same edge: the read returns the pre-write value.
- bvalid and rvalid never depend combinationally on bready/rready. All outputs are registered.
- Reset asserted mid-transaction: all state returns to reset values at that edge, any pending transaction is dropped without a response, and registers clear to 0.

## Test plan
- Simultaneous AW+W: awaddr=0x04, wdata=0xDEADBEEF, wstrb=0xF → bvalid at N+1 with bresp=00; reg_q[63:32]=0xDEADBEEF; wr_stb=0x0002 for one cycle.
- W before AW by 3 cycles, then AW to reg 2 with wstrb=0x5 over initial value 0x11223344, wdata=0xAABBCCDD → reg 2 = 0x11BB33DD. Also check wready=0 while waiting for AW.
- Read reg 1 with rready held low for 4 cycles → rvalid/rdata=0xDEADBEEF stable throughout; arready=0 until the rready handshake.
- Out-of-range accesses (REG_NUM=16, DATA_W=32):
  - Write to 0x40 → bresp=10, no reg_q change, wr_stb=0.
  - Read from 0x7C → rresp=10, rdata=0.
- Same-edge read and commit to reg 3 (old 0x0, new 0x5) → rdata=0x0; a following read returns 0x5.
- rst pulsed while in WR_RESP with bready=0 → next cycle bvalid=0, reg_q=0; one cycle later awready=wready=arready=1.

Source files
------------

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite slave that exposes REG_NUM read/write registers as a flat vector.
// After each committed write it pulses a per-register strobe for one cycle.
//
// state      | meaning
// WR_COLLECT | accepting AW and W independently until both are held
// WR_COMMIT  | apply strobed write (or reject out of range), raise bvalid
// WR_RESP    | hold bresp until bready
// RD_IDLE    | arready high, capture read on handshake
// RD_RESP    | hold rdata/rresp until rready
module axi_lite_reg_slave #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ADDR_W-1:0]         awaddr,
  input  logic [2:0]                awprot,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ADDR_W-1:0]         araddr,
  input  logic [2:0]                arprot,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DATA_W-1:0]         rdata,
  output logic [1:0]                rresp,
  output logic [REG_NUM*DATA_W-1:0] reg_q,
  output logic [REG_NUM-1:0]        wr_stb
);
  localparam int LSB    = $clog2(DATA_W / 8);
  localparam int IDX_W  = ADDR_W - LSB;
  localparam int SEL_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] WR_COLLECT = 2'd0;
  localparam logic [1:0] WR_COMMIT  = 2'd1;
  localparam logic [1:0] WR_RESP    = 2'd2;
  localparam logic [0:0] RD_IDLE    = 1'b0;
  localparam logic [0:0] RD_RESP    = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_W-1:0] regs [REG_NUM];
  logic [1:0]        wr_state;
  logic [0:0]        rd_state;
  logic              aw_held, w_held;
  logic [IDX_W-1:0]  aw_idx;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0]  ar_idx;
  logic              aw_ok, ar_ok;
  logic [SEL_W-1:0]  aw_sel, ar_sel;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign ar_idx = araddr[ADDR_W-1:LSB];
  assign aw_ok  = {{(32-IDX_W){1'b0}}, aw_idx} < 32'(REG_NUM);
  assign ar_ok  = {{(32-IDX_W){1'b0}}, ar_idx} < 32'(REG_NUM);
  assign aw_sel = aw_idx[SEL_W-1:0];
  assign ar_sel = ar_idx[SEL_W-1:0];

  // Byte-offset bits and protection attributes carry no meaning here.
  logic unused;
  assign unused = ^{awprot, arprot, awaddr[LSB-1:0], araddr[LSB-1:0]};

  for (genvar i = 0; i < REG_NUM; i++) begin : g_flat
    assign reg_q[i*DATA_W +: DATA_W] = regs[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_COLLECT;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      wr_stb   <= '0;
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else begin
      wr_stb <= '0;
      case (wr_state)
        WR_COLLECT: begin
          if (aw_hs) begin
            aw_held <= 1'b1;
            aw_idx  <= awaddr[ADDR_W-1:LSB];
          end
          if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
          end
          // Readies are registered, so they reflect the held flags after this edge.
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            wr_state <= WR_COMMIT;
            awready  <= 1'b0;
            wready   <= 1'b0;
          end else begin
            awready <= !(aw_held || aw_hs);
            wready  <= !(w_held || w_hs);
          end
        end
        WR_COMMIT: begin
          if (aw_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (wstrb_q[b]) regs[aw_sel][8*b +: 8] <= wdata_q[8*b +: 8];
            end
            wr_stb[aw_sel] <= 1'b1;
          end
          bvalid   <= 1'b1;
          bresp    <= aw_ok ? RESP_OKAY : RESP_SLVERR;
          wr_state <= WR_RESP;
        end
        WR_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
            wr_state <= WR_COLLECT;
          end
        end
        default: wr_state <= WR_COLLECT;
      endcase
    end
  end

  // Reads sample regs before any same-edge commit lands, returning the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rdata    <= ar_ok ? regs[ar_sel] : '0;
            rresp    <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            rvalid   <= 1'b1;
            arready  <= 1'b0;
            rd_state <= RD_RESP;
          end else begin
            arready <= 1'b1;
          end
        end
        RD_RESP: begin
          if (rready) begin
            rvalid   <= 1'b0;
            arready  <= 1'b1;
            rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: scoreboard queues hold expected
// responses pushed at issue time and popped when the DUT responds.
module tb_axi_lite_reg_slave;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         awvalid = 0, awready;
  logic [7:0]   awaddr = 0;
  logic [2:0]   awprot = 0;
  logic         wvalid = 0, wready;
  logic [31:0]  wdata = 0;
  logic [3:0]   wstrb = 0;
  logic         bvalid, bready = 0;
  logic [1:0]   bresp;
  logic         arvalid = 0, arready;
  logic [7:0]   araddr = 0;
  logic [2:0]   arprot = 0;
  logic         rvalid, rready = 0;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic [511:0] reg_q;
  logic [15:0]  wr_stb;

  axi_lite_reg_slave #(.ADDR_W(8), .DATA_W(32), .REG_NUM(16)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .reg_q(reg_q), .wr_stb(wr_stb)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  logic [31:0] model [16];

  function automatic logic [511:0] model_vec();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
    logic       ok;
    int         idx, n;
    logic [1:0] e;
    idx = int'(a[7:2]);
    ok  = idx < 16;
    bq.push_back(ok ? 2'b00 : 2'b10);
    wvalid = 1; wdata = d; wstrb = s;
    for (int k = 0; k < lead; k++) begin
      tick();
      wvalid = 0;
      chk("wready_low_waiting_aw", wready, 0);
    end
    awvalid = 1; awaddr = a;
    tick();
    awvalid = 0; wvalid = 0;
    chk("awready_low_after_hs", awready, 0);
    n = 0;
    while (!bvalid && n < 8) begin tick(); n++; end
    chk("write_latency", n, 1);
    e = bq.pop_front();
    chk("bresp", bresp, e);
    if (ok) for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    chk("wr_stb_pulse", wr_stb, ok ? 16'(1 << idx) : 16'h0);
    chk("reg_q_after_write", reg_q, model_vec());
    tick();
    chk("bvalid_hold", bvalid, 1);
    chk("wr_stb_one_cycle", wr_stb, 0);
    bready = 1;
    tick();
    bready = 0;
    chk("bvalid_clear", bvalid, 0);
  endtask

  task automatic rd(input logic [7:0] a, input int hold);
    int          idx, n;
    logic [33:0] e;
    idx = int'(a[7:2]);
    rq.push_back(idx < 16 ? {2'b00, model[idx[3:0]]} : {2'b10, 32'h0});
    arvalid = 1; araddr = a;
    tick();
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 8) begin tick(); n++; end
    chk("read_latency", n, 0);
    e = rq.pop_front();
    chk("rdata", rdata, e[31:0]);
    chk("rresp", rresp, e[33:32]);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("rvalid_hold", rvalid, 1);
      chk("rdata_stable", rdata, e[31:0]);
      chk("arready_low_busy", arready, 0);
    end
    rready = 1;
    tick();
    rready = 0;
    chk("rvalid_clear", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  initial begin
    logic [33:0] re;
    logic [1:0]  be;
    for (int i = 0; i < 16; i++) model[i] = '0;

    repeat (3) tick();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_reg_q", reg_q, 0);
    chk("rst_wr_stb", wr_stb, 0);
    rst = 0;
    tick();
    chk("ready_after_rst", {awready, wready, arready}, 3'b111);

    wr(8'h04, 32'hDEADBEEF, 4'hF, 0);
    chk("reg1_value", reg_q[63:32], 32'hDEADBEEF);
    wr(8'h08, 32'h11223344, 4'hF, 0);
    wr(8'h08, 32'hAABBCCDD, 4'h5, 3);
    chk("reg2_strobed", reg_q[95:64], 32'h11BB33DD);
    rd(8'h04, 4);
    wr(8'h40, 32'hCAFEF00D, 4'hF, 0);
    rd(8'h7C, 0);
    wr(8'h14, 32'h12345678, 4'h0, 0);
    rd(8'h08, 0);

    // Read of reg 3 lands on the same edge as its commit.
    rq.push_back({2'b00, model[3]});
    bq.push_back(2'b00);
    awvalid = 1; awaddr = 8'h0C; wvalid = 1; wdata = 32'h5; wstrb = 4'hF;
    tick();
    awvalid = 0; wvalid = 0;
    arvalid = 1; araddr = 8'h0C;
    tick();
    arvalid = 0;
    model[3] = 32'h5;
    re = rq.pop_front();
    be = bq.pop_front();
    chk("same_edge_rvalid", rvalid, 1);
    chk("same_edge_rdata_old", rdata, re[31:0]);
    chk("same_edge_bvalid", bvalid, 1);
    chk("same_edge_bresp", bresp, be);
    chk("same_edge_reg_q", reg_q, model_vec());
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    rd(8'h0C, 0);

    // Reset while a response is pending: it is dropped.
    awvalid = 1; awaddr = 8'h18; wvalid = 1; wdata = 32'h1234; wstrb = 4'hF;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    chk("pre_rst_bvalid", bvalid, 1);
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    chk("midrst_bvalid", bvalid, 0);
    chk("midrst_reg_q", reg_q, model_vec());
    chk("midrst_readies", {awready, wready, arready}, 3'b000);
    tick();
    chk("post_rst_readies", {awready, wready, arready}, 3'b111);
    chk("post_rst_bvalid", bvalid, 0);

    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
